// File: rtl/tohost_txq.sv
// tohost_txq: console output stage between the core's tohost MMIO writes
// and the UART transmitter. Decodes tohost words, queues print characters
// in a FIFO, drains them with a WE/READY handshake, and raises DONE once an
// exit has been seen and all output has left the transmitter.
// Optional feature macro: TOHOST_CRLF_EN (expand LF into CR,LF on the wire).
module tohost_txq #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST_X,
  input  logic                     WE,
  input  logic [31:0]              WDATA,
  output logic [7:0]               TX_DATA,
  output logic                     TX_WE,
  input  logic                     TX_READY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     OVF,
  output logic [15:0]              EXIT_CODE,
  output logic                     DONE
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count_d;
  logic            exit_pend;
  logic            wr_ok, push_req, push_ok, exit_req;
  logic            issue, pop;
  logic [7:0]      head_byte, tx_byte;
  logic            done_cond;
  logic            unused_wdata;
`ifdef TOHOST_CRLF_EN
  logic            cr_sent, cr_set, cr_clr;
`endif

  // Upper tohost bits carry no meaning for this stage
  assign unused_wdata = ^WDATA[31:18];

  // Command decode; everything is ignored once an exit is pending
  assign wr_ok     = WE && !exit_pend;
  assign push_req  = wr_ok && (WDATA[17:16] == 2'd1);
  assign exit_req  = wr_ok && (WDATA[17:16] == 2'd2);
  assign push_ok   = push_req && !FULL;
  assign head_byte = mem[head];

  // Drain FSM state register
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Drain FSM next state and issue decision
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    pop     = 1'b0;
    tx_byte = head_byte;
`ifdef TOHOST_CRLF_EN
    cr_set  = 1'b0;
    cr_clr  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!EMPTY && TX_READY) begin
          issue   = 1'b1;
          state_d = S_ISSUE;
`ifdef TOHOST_CRLF_EN
          // LF at head: send CR first and leave LF in place for the next issue
          if (head_byte == 8'h0A && !cr_sent) begin
            tx_byte = 8'h0D;
            cr_set  = 1'b1;
          end else begin
            pop    = 1'b1;
            cr_clr = 1'b1;
          end
`else
          pop = 1'b1;
`endif
        end
      end
      S_ISSUE: state_d = S_HOLD;
      // READY is ignored here: the transmitter drops it one cycle late
      S_HOLD:  state_d = S_WAIT;
      S_WAIT:  if (TX_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Occupancy after this edge's push/pop
  always_comb begin
    count_d = COUNT;
    case ({push_ok, pop})
      2'b10:   count_d = COUNT + CW'(1);
      2'b01:   count_d = COUNT - CW'(1);
      default: count_d = COUNT;
    endcase
  end

`ifdef TOHOST_CRLF_EN
  assign done_cond = exit_pend && EMPTY && (state_q == S_IDLE) && TX_READY && !cr_sent;
`else
  assign done_cond = exit_pend && EMPTY && (state_q == S_IDLE) && TX_READY;
`endif

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (push_ok) mem[tail] <= WDATA[7:0];
  end

  // Pointers, occupancy and status flags
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      head  <= '0;
      tail  <= '0;
      COUNT <= '0;
      FULL  <= 1'b0;
      EMPTY <= 1'b1;
      OVF   <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + AW'(1);
      if (pop)     head <= head + AW'(1);
      if (push_req && FULL) OVF <= 1'b1;
      COUNT <= count_d;
      FULL  <= (count_d == CW'(DEPTH));
      EMPTY <= (count_d == CW'(0));
    end
  end

  // Transmitter interface; TX_DATA holds the last byte sent
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      TX_DATA <= 8'h00;
      TX_WE   <= 1'b0;
    end else begin
      TX_WE <= issue;
      if (issue) TX_DATA <= tx_byte;
    end
  end

  // Exit tracking and sticky completion
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      exit_pend <= 1'b0;
      EXIT_CODE <= 16'h0000;
      DONE      <= 1'b0;
    end else begin
      if (exit_req) begin
        exit_pend <= 1'b1;
        EXIT_CODE <= WDATA[15:0];
      end
      if (done_cond) DONE <= 1'b1;
    end
  end

`ifdef TOHOST_CRLF_EN
  // Tracks that the CR for the LF at head has already gone out
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X)      cr_sent <= 1'b0;
    else if (cr_set) cr_sent <= 1'b1;
    else if (cr_clr) cr_sent <= 1'b0;
  end
`endif

endmodule
